// File: rtl/hc153_pkg.sv
// ============================================================================
// Package   : hc153_pkg
// Purpose   : Shared types and constants for the dual 4:1 mux scan reader.
//             Holds the slot/select encoding, the FSM state type and the
//             minimum legal slot length.
// Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

package hc153_pkg;

  // Slot index; doubles as the {S1,S2} select value for that slot.
  typedef logic [1:0] slot_t;

  localparam slot_t SEL_I0 = 2'b00;
  localparam slot_t SEL_I1 = 2'b01;
  localparam slot_t SEL_I2 = 2'b10;
  localparam slot_t SEL_I3 = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // One cycle of external mux settling plus two synchronizer stages.
  localparam int SETTLE_MIN = 3;

endpackage

`default_nettype wire

// File: rtl/hc153_scan_rx_sync2.sv
// ============================================================================
// Module    : sync2
// Purpose   : Generic two-flop synchronizer for a single-bit asynchronous
//             input, with asynchronous active-high reset to 0.
// Ports     : clk_i  - destination clock
//             rst_i  - asynchronous active-high reset
//             d_i    - asynchronous data in
//             q_o    - synchronized data out (two clk_i edges of latency)
// Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

module sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/hc153_scan_rx.sv
// ============================================================================
// Module    : hc153_scan_rx
// Purpose   : Sequential reader for an external dual 4:1 multiplexer. Steps
//             the mux selects through inputs 0..3, samples both mux outputs
//             once per slot through 2-flop synchronizers and presents the
//             rebuilt 4-bit words in parallel with a one-cycle VALID pulse.
// Ports     : CLK, RST        - clock, asynchronous active-high reset
//             START           - frame request (sampled in IDLE only)
//             CONT            - continuous mode, checked at frame end
//             EN1, EN2        - channel enables, latched at frame start
//             Y1, Y2          - asynchronous mux outputs
//             S1, S2          - select MSB/LSB to the mux
//             E1N, E2N        - active-low channel strobes
//             Q1, Q2 [0:3]    - rebuilt words, Qn[k] = mux input k
//             VALID           - one-cycle pulse after Q1/Q2 update
//             BUSY            - frame in progress
// Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

module hc153_scan_rx
  import hc153_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int CNT_W      = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       CONT,
  input  logic       EN1,
  input  logic       EN2,
  input  logic       Y1,
  input  logic       Y2,
  output logic       S1,
  output logic       S2,
  output logic       E1N,
  output logic       E2N,
  output logic [0:3] Q1,
  output logic [0:3] Q2,
  output logic       VALID,
  output logic       BUSY
);

  // Elaboration-time parameter sanity.
  if (SETTLE_CYC < SETTLE_MIN || SETTLE_CYC > 15) begin : g_bad_settle
    $error("hc153_scan_rx: SETTLE_CYC out of range 3..15");
  end
  if ((2 ** CNT_W) <= SETTLE_CYC) begin : g_bad_cnt_w
    $error("hc153_scan_rx: CNT_W too small for SETTLE_CYC");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  slot_t            sel_q;
  logic             en1_q, en2_q;
  logic             e1n_q, e2n_q;
  logic [0:2]       shadow1_q, shadow2_q;
  logic [0:3]       q1_q, q2_q;
  logic             valid_q;
  logic             busy_q;

  logic y1_s, y2_s;
  logic slot_end;
  logic frame_end;

  sync2 u_sync_y1 (.clk_i(CLK), .rst_i(RST), .d_i(Y1), .q_o(y1_s));
  sync2 u_sync_y2 (.clk_i(CLK), .rst_i(RST), .d_i(Y2), .q_o(y2_s));

  assign slot_end  = (cnt_q == CNT_LAST);
  assign frame_end = slot_end && (sel_q == SEL_I3);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sel_q     <= SEL_I0;
      en1_q     <= 1'b0;
      en2_q     <= 1'b0;
      e1n_q     <= 1'b1;
      e2n_q     <= 1'b1;
      shadow1_q <= '0;
      shadow2_q <= '0;
      q1_q      <= '0;
      q2_q      <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (START) begin
            state_q <= SCAN;
            en1_q   <= EN1;
            en2_q   <= EN2;
            e1n_q   <= ~EN1;
            e2n_q   <= ~EN2;
            sel_q   <= SEL_I0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SCAN: begin
          if (!slot_end) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            cnt_q <= '0;
            if (!frame_end) begin
              shadow1_q[sel_q] <= y1_s;
              shadow2_q[sel_q] <= y2_s;
              sel_q            <= sel_q + 2'd1;
            end else begin
              // Slot 3 goes straight from the synchronizer so the whole
              // word updates on this one edge.
              q1_q    <= en1_q ? {shadow1_q, y1_s} : 4'b0000;
              q2_q    <= en2_q ? {shadow2_q, y2_s} : 4'b0000;
              valid_q <= 1'b1;
              sel_q   <= SEL_I0;
              if (CONT) begin
                en1_q <= EN1;
                en2_q <= EN2;
                e1n_q <= ~EN1;
                e2n_q <= ~EN2;
              end else begin
                state_q <= IDLE;
                e1n_q   <= 1'b1;
                e2n_q   <= 1'b1;
                busy_q  <= 1'b0;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign S1    = sel_q[1];
  assign S2    = sel_q[0];
  assign E1N   = e1n_q;
  assign E2N   = e2n_q;
  assign Q1    = q1_q;
  assign Q2    = q2_q;
  assign VALID = valid_q;
  assign BUSY  = busy_q;

endmodule

`default_nettype wire

// File: doc/hc153_scan_rx.md
Name: hc153_scan_rx

Overview:
- Sequential reader for the dual 4-to-1 multiplexer interface.
- Drives the select lines (S1, S2) and the active-low strobes (E1N, E2N) of an external dual 4:1 mux, then samples its two outputs (Y1, Y2) slot by slot.
- Rebuilds the two 4-bit input words that the mux serialises and presents them as parallel registered words with a valid pulse.
- Sits at the board edge, between the mux pins and on-chip logic.

Parameters:
- SETTLE_CYC, 4: clock cycles per slot, measured from a select change to the capture of that slot. Legal range 3..15. The minimum of 3 covers one cycle of external mux settling plus the 2-flop synchronizer.
- CNT_W, 4: width of the slot cycle counter. Must satisfy 2**CNT_W > SETTLE_CYC.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  frame request. Sampled only in IDLE.
- CONT  in  1  continuous mode. When 1 at frame end, the next frame starts immediately.
- EN1  in  1  channel-1 enable. Latched at frame start.
- EN2  in  1  channel-2 enable. Latched at frame start.
- Y1  in  1  mux channel-1 output. Asynchronous to CLK.
- Y2  in  1  mux channel-2 output. Asynchronous to CLK.
- S1  out  1  select MSB to the mux (0 selects inputs 0/1, 1 selects inputs 2/3).
- S2  out  1  select LSB to the mux (0 selects inputs 0/2, 1 selects inputs 1/3).
- E1N  out  1  channel-1 strobe, active low. Registered.
- E2N  out  1  channel-2 strobe, active low. Registered.
- Q1  out  [0:3]  reconstructed channel-1 word; Q1[k] is the value of mux input k.
- Q2  out  [0:3]  reconstructed channel-2 word.
- VALID  out  1  one-cycle pulse: Q1/Q2 were updated on the preceding edge.
- BUSY  out  1  high while a frame is in progress.

Behaviour:
- Interface: one clock (CLK); reset (RST) is asynchronous and active-high.
- Reset values: S1=0, S2=0, E1N=1, E2N=1, Q1=0000, Q2=0000, VALID=0, BUSY=0. Synchronizers cleared, state IDLE, slot index 0, counter 0.
- Mux model: Y = !EN_N & I[{S1,S2}]. A disabled channel returns 0.
- Synchronization: Y1 and Y2 each pass through a 2-flop synchronizer. Only synchronized values are captured.
- FSM, two states:
  - IDLE -> SCAN when START=1 at an edge (edge e0). At e0: latch EN1/EN2, drive E1N=!EN1 and E2N=!EN2, set {S1,S2}=00, slot index=0, counter=0, BUSY=1.
  - SCAN: the counter increments every edge. At the edge where the counter reaches SETTLE_CYC-1, capture synchronized Y1 into shadow1[idx] and Y2 into shadow2[idx], clear the counter, and advance idx and {S1,S2} by one (00->01->10->11).
  - Slot k therefore holds select=k for exactly SETTLE_CYC cycles. Capture of slot k occurs at edge e0+(k+1)*SETTLE_CYC.
- Frame end, at edge e0+4*SETTLE_CYC:
  - Q1 and Q2 load all four bits atomically (bits 0..2 from the shadow registers, bit 3 taken directly from the synchronizer). A latched-disabled channel loads 0000.
  - VALID=1 for exactly one cycle.
  - If CONT=1: restart as at e0 (re-latch EN1/EN2, select 00, BUSY stays 1).
  - Else: go to IDLE, select 00, E1N=E2N=1, BUSY=0.
- Latency: VALID is high in the cycle after edge e0+4*SETTLE_CYC, i.e. 16 cycles after START with default parameters.
- Q1 and Q2 are stable between VALID pulses and are never partially updated.
- START while BUSY is ignored and not queued.
- EN1/EN2 changes mid-frame have no effect until the next frame start.
- Select wrap 11->00 occurs only through the frame-end restart, never mid-frame.
- Reset mid-frame: all outputs return to reset values immediately. Q is cleared and no VALID pulse is issued for the aborted frame.
- START held high continuously in IDLE restarts a new frame on the edge after returning to IDLE. Frames are back-to-back with one idle cycle between them.

Decomposition:
- Shared package hc153_pkg:
  - slot index type (2 bits);
  - select encoding constants SEL_I0=00, SEL_I1=01, SEL_I2=10, SEL_I3=11 as {S1,S2};
  - FSM state enum {IDLE, SCAN};
  - SETTLE_MIN=3.
- One sub-module, sync2: generic 2-flop synchronizer with asynchronous reset, instantiated once per Y input.

Test Plan:
- Reset/idle: assert RST mid-idle -> S1S2=00, E1N=E2N=1, Q1=Q2=0000, VALID=0, BUSY=0. Holding START=0 for 50 cycles leaves all outputs unchanged.
- Single frame: bench mux with I1=1011 (I1[0]=1), I2=0110, EN1=EN2=1, SETTLE_CYC=4, pulse START -> select sequence 00,01,10,11 with 4 cycles each. VALID in cycle 16 after START with Q1=1011, Q2=0110, then BUSY=0 and E1N=E2N=1.
- Disabled channel: EN1=1, EN2=0, I2=1111 -> E2N=1 throughout the frame and Q2=0000. Q1 matches I1.
- Continuous mode: CONT=1 with I1 changed from 0001 to 1000 between frames -> VALID every 16 cycles with no gap. Consecutive Q1 values are 0001 then 1000, and S1S2 wraps 11->00.
- Abort: assert RST at cycle 9 of a frame -> immediate reset values. A fresh START then yields a correct frame with VALID after 16 cycles.
- Boundary: START pulse while BUSY -> ignored, exactly one VALID. SETTLE_CYC=3 with the bench mux responding in one cycle -> correct words after 12 cycles.
